// File: rtl/iotdf_pkg.sv
// rtl/iotdf_pkg.sv - shared types and helpers for the multi-function IoT data filter
package iotdf_pkg;

    typedef enum logic [2:0] {
        FN_RANGE = 3'd0,
        FN_MAX   = 3'd1,
        FN_MIN   = 3'd2,
        FN_AVG   = 3'd3,
        FN_EXT   = 3'd4,
        FN_EXC   = 3'd5,
        FN_PMAX  = 3'd6,
        FN_PMIN  = 3'd7
    } fn_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_e;

    // Shift that turns a group sum into an average; GRP is a power of two.
    function automatic int grp_sh(input int grp);
        return $clog2(grp);
    endfunction

    // Extract/exclude judge every sample on its own; all others work on groups.
    function automatic logic is_sample_mode(input fn_e m);
        return (m == FN_EXT) || (m == FN_EXC);
    endfunction

endpackage

// File: rtl/iotdf_deser.sv
// rtl/iotdf_deser.sv - MSB-first beat-to-sample deserialiser
//
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   in_en, iot_in  input beat and its valid
//   busy           beats presented while busy are dropped
//   word           sample including the beat being accepted this cycle
//   word_done      combinational pulse: this cycle's beat completes the sample
//   beat_first     combinational pulse: this cycle's beat starts a sample
module iotdf_deser #(
    parameter int DATA_W = 128,
    parameter int IN_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic              busy,
    input  logic [IN_W-1:0]   iot_in,
    output logic [DATA_W-1:0] word,
    output logic              word_done,
    output logic              beat_first
);

    localparam int BEATS = DATA_W / IN_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] sreg_q;
    logic              accept;

    assign accept     = in_en && !busy;
    // The sample is presented combinationally so the top can act on it in the
    // same edge that accepts the final beat.
    assign word       = DATA_W'({sreg_q, iot_in});
    assign word_done  = accept && (cnt_q == CW'(BEATS - 1));
    assign beat_first = accept && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            sreg_q <= '0;
        end else if (accept) begin
            sreg_q <= word;
            cnt_q  <= word_done ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/iotdf_multi.sv
// rtl/iotdf_multi.sv - eight-function IoT sample filter / group statistics
//
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   in_en, iot_in  IN_W-bit input beat stream, MSB beat first
//   fn_sel         function select, latched at group/sample start
//   low, high      thresholds for extract/exclude
//   busy           next beat will be dropped
//   valid, iot_out one-cycle result pulse and held result
module iotdf_multi
    import iotdf_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int IN_W   = 8,
    parameter int GRP    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic [IN_W-1:0]   iot_in,
    input  logic [2:0]        fn_sel,
    input  logic [DATA_W-1:0] low,
    input  logic [DATA_W-1:0] high,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] iot_out
);

    localparam int GRP_SH = grp_sh(GRP);
    localparam int SW     = DATA_W + GRP_SH;

    state_e              state_q, state_d;
    fn_e                 mode_q, mode_eff;
    logic [GRP_SH-1:0]   scnt_q;
    logic [DATA_W-1:0]   max_q, min_q, peak_q, out_q;
    logic [SW-1:0]       sum_q;
    logic                peak_seen_q, valid_q;

    logic [DATA_W-1:0]   x, nmax, nmin, result;
    logic [SW-1:0]       nsum;
    logic                word_done, beat_first, accept, latch;
    logic                grp_first, sample_mode, trigger, emit_ok;

    iotdf_deser #(.DATA_W(DATA_W), .IN_W(IN_W)) u_deser (
        .clk        (clk),
        .rst        (rst),
        .in_en      (in_en),
        .busy       (busy),
        .iot_in     (iot_in),
        .word       (x),
        .word_done  (word_done),
        .beat_first (beat_first)
    );

    // busy depends only on registers, so there is no loop through accept.
    assign busy    = (state_q == EMIT) && !is_sample_mode(mode_q);
    assign valid   = valid_q;
    assign iot_out = out_q;
    assign accept  = in_en && !busy;

    // Per-sample modes keep scnt_q at 0, so every sample start is a latch point.
    assign grp_first   = (scnt_q == '0);
    assign latch       = beat_first && grp_first;
    assign mode_eff    = latch ? fn_e'(fn_sel) : mode_q;
    assign sample_mode = is_sample_mode(mode_eff);
    assign trigger     = word_done && (sample_mode || scnt_q == GRP_SH'(GRP - 1));

    // Running statistics including the sample completing this cycle.
    assign nmax = (grp_first || x > max_q) ? x : max_q;
    assign nmin = (grp_first || x < min_q) ? x : min_q;
    assign nsum = grp_first ? SW'(x) : sum_q + SW'(x);

    always_comb begin
        result  = nmax;
        emit_ok = 1'b0;
        unique case (mode_eff)
            FN_RANGE: begin result = nmax - nmin;          emit_ok = 1'b1; end
            FN_MAX:   begin result = nmax;                 emit_ok = 1'b1; end
            FN_MIN:   begin result = nmin;                 emit_ok = 1'b1; end
            FN_AVG:   begin result = DATA_W'(nsum >> GRP_SH); emit_ok = 1'b1; end
            FN_EXT:   begin result = x; emit_ok = (low < x) && (x < high); end
            FN_EXC:   begin result = x; emit_ok = (x < low) || (x > high); end
            FN_PMAX:  begin result = nmax; emit_ok = !peak_seen_q || (nmax > peak_q); end
            FN_PMIN:  begin result = nmin; emit_ok = !peak_seen_q || (nmin < peak_q); end
            default:  begin result = nmax; emit_ok = 1'b0; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger) state_d = EMIT; else if (accept) state_d = ACCUM;
            ACCUM:   if (trigger) state_d = EMIT;
            EMIT:    if (trigger) state_d = EMIT; else if (in_en) state_d = ACCUM; else state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q      <= FN_RANGE;
            scnt_q      <= '0;
            max_q       <= '0;
            min_q       <= '0;
            sum_q       <= '0;
            peak_q      <= '0;
            peak_seen_q <= 1'b0;
            valid_q     <= 1'b0;
            out_q       <= '0;
        end else begin
            valid_q <= 1'b0;
            if (latch) begin
                mode_q <= fn_e'(fn_sel);
                // A new mode restarts the peak tracking from scratch.
                if (fn_e'(fn_sel) != mode_q) peak_seen_q <= 1'b0;
                if (is_sample_mode(fn_e'(fn_sel))) begin
                    max_q <= '0;
                    min_q <= '0;
                    sum_q <= '0;
                end
            end
            if (word_done) begin
                if (sample_mode) begin
                    scnt_q <= '0;
                end else begin
                    scnt_q <= scnt_q + 1'b1;
                    max_q  <= nmax;
                    min_q  <= nmin;
                    sum_q  <= nsum;
                end
            end
            if (trigger && emit_ok) begin
                valid_q <= 1'b1;
                out_q   <= result;
                if (mode_eff == FN_PMAX || mode_eff == FN_PMIN) begin
                    peak_q      <= result;
                    peak_seen_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iotdf_multi.sv
// tb/tb_iotdf_multi.sv - directed self-checking bench for iotdf_multi
module tb_iotdf_multi;

    localparam int DATA_W = 128;
    localparam int IN_W   = 8;
    localparam int GRP    = 8;
    localparam int BEATS  = DATA_W / IN_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_en;
    logic [IN_W-1:0]   iot_in;
    logic [2:0]        fn_sel;
    logic [DATA_W-1:0] low, high;
    logic              busy, valid;
    logic [DATA_W-1:0] iot_out;

    int errors = 0;
    int checks = 0;
    int vcount, bcount, vb_mis;
    logic [DATA_W-1:0] outq [$];
    logic [DATA_W-1:0] grp_v [GRP];

    always #5 clk = ~clk;

    iotdf_multi #(.DATA_W(DATA_W), .IN_W(IN_W), .GRP(GRP)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_en   (in_en),
        .iot_in  (iot_in),
        .fn_sel  (fn_sel),
        .low     (low),
        .high    (high),
        .busy    (busy),
        .valid   (valid),
        .iot_out (iot_out)
    );

    always @(negedge clk) begin
        if (valid) begin
            outq.push_back(iot_out);
            vcount++;
        end
        if (busy) bcount++;
        if (valid != busy) vb_mis++;
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        outq.delete();
        vcount = 0;
        bcount = 0;
        vb_mis = 0;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] b);
        int waitc = 0;
        @(negedge clk);
        while (busy && waitc < 100) begin
            in_en = 1'b0;
            @(negedge clk);
            waitc++;
        end
        if (busy) check("busy_timeout", 1, 0);
        in_en  = 1'b1;
        iot_in = b;
    endtask

    task automatic send_sample(input logic [DATA_W-1:0] s);
        for (int i = 0; i < BEATS; i++) send_beat(s[DATA_W-1-IN_W*i -: IN_W]);
    endtask

    task automatic send_grp();
        for (int i = 0; i < GRP; i++) send_sample(grp_v[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_en = 1'b0;
        end
    endtask

    // Next negedge after the final beat: result must already be visible.
    task automatic end_grp_chk(input string tag, input logic [DATA_W-1:0] exp);
        @(negedge clk);
        in_en = 1'b0;
        check({tag, "_valid"}, valid, 1);
        check({tag, "_busy"}, busy, 1);
        check(tag, iot_out, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_en = 1'b0; iot_in = '0; fn_sel = 3'd0; low = '0; high = '0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_out", iot_out, 0);
        rst = 1'b1;

        // group max, two groups
        fn_sel = 3'd1;
        clear_mon();
        for (int i = 0; i < GRP; i++) grp_v[i] = DATA_W'(i + 1);
        send_grp();
        end_grp_chk("t1_max_a", 8);
        for (int i = 0; i < GRP; i++) grp_v[i] = DATA_W'(16 - i);
        send_grp();
        idle(3);
        check("t1_count", outq.size(), 2);
        if (outq.size() == 2) begin
            check("t1_out0", outq[0], 8);
            check("t1_out1", outq[1], 16);
        end
        check("t1_busy_cycles", bcount, 2);
        check("t1_busy_eq_valid", vb_mis, 0);

        // average: saturating-width sum then small values
        fn_sel = 3'd3;
        for (int i = 0; i < GRP; i++) grp_v[i] = '1;
        send_grp();
        end_grp_chk("t2_avg_ones", '1);
        for (int i = 0; i < GRP; i++) grp_v[i] = DATA_W'(i);
        send_grp();
        end_grp_chk("t2_avg_0_7", 3);
        idle(2);

        // extract, strict bounds, full rate
        fn_sel = 3'd4;
        low  = {4'h6, {31{4'hF}}};
        high = {4'hA, {31{4'hF}}};
        clear_mon();
        send_sample({4'h7, 124'h0});
        send_sample({4'h6, {31{4'hF}}});
        send_sample({4'hA, {31{4'hF}}});
        send_sample({4'h8, 124'h0});
        idle(3);
        check("t3_count", outq.size(), 2);
        if (outq.size() == 2) begin
            check("t3_out0", outq[0], {4'h7, 124'h0});
            check("t3_out1", outq[1], {4'h8, 124'h0});
        end
        check("t3_no_busy", bcount, 0);
        check("t3_hold", iot_out, {4'h8, 124'h0});

        // exclude with low == high
        fn_sel = 3'd5;
        low = 5; high = 5;
        clear_mon();
        send_sample(5);
        send_sample(4);
        send_sample(6);
        idle(3);
        check("t3x_count", outq.size(), 2);
        if (outq.size() == 2) begin
            check("t3x_out0", outq[0], 4);
            check("t3x_out1", outq[1], 6);
        end

        // peak max over group maxima 50, 40, 50, 70
        fn_sel = 3'd6;
        clear_mon();
        foreach (grp_v[i]) grp_v[i] = 1;
        grp_v[0] = 50; send_grp();
        grp_v[0] = 40; send_grp();
        grp_v[0] = 50; send_grp();
        grp_v[0] = 70; send_grp();
        idle(3);
        check("t4_pmax_count", outq.size(), 2);
        if (outq.size() == 2) begin
            check("t4_pmax0", outq[0], 50);
            check("t4_pmax1", outq[1], 70);
        end
        check("t4_pmax_busy", bcount, 4);

        // peak min over group minima 9, 9, 3
        fn_sel = 3'd7;
        clear_mon();
        foreach (grp_v[i]) grp_v[i] = 200;
        grp_v[0] = 9; send_grp();
        grp_v[0] = 9; send_grp();
        grp_v[0] = 3; send_grp();
        idle(3);
        check("t4_pmin_count", outq.size(), 2);
        if (outq.size() == 2) begin
            check("t4_pmin0", outq[0], 9);
            check("t4_pmin1", outq[1], 3);
        end

        // range
        fn_sel = 3'd0;
        grp_v[0] = 5; grp_v[1] = 100; grp_v[2] = 7; grp_v[3] = 8;
        grp_v[4] = 9; grp_v[5] = 10; grp_v[6] = 11; grp_v[7] = 12;
        send_grp();
        end_grp_chk("t5_range", 95);
        idle(2);

        // reset mid-group, then group min from post-reset data only
        fn_sel = 3'd2;
        send_sample(1);
        send_sample(1);
        for (int i = 0; i < 8; i++) send_beat(8'hAB);
        @(negedge clk);
        rst = 1'b0;
        in_en = 1'b1;
        iot_in = 8'h01;
        @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_out", iot_out, 0);
        rst = 1'b1;
        in_en = 1'b0;
        for (int i = 0; i < GRP; i++) grp_v[i] = DATA_W'(50 + i);
        send_grp();
        end_grp_chk("t6_min_post_rst", 50);

        // beat offered during busy must be dropped
        for (int i = 0; i < GRP; i++) grp_v[i] = DATA_W'(30 + i);
        send_grp();
        @(negedge clk);
        check("t6_busy_before_drop", busy, 1);
        check("t6_min_30", iot_out, 30);
        in_en = 1'b1;
        iot_in = 8'h00;
        for (int i = 0; i < GRP; i++) grp_v[i] = DATA_W'(40 + i);
        send_grp();
        end_grp_chk("t6_min_after_drop", 40);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
